// File: rtl/lfsr_response_checker.sv
// lfsr_response_checker
//   Receiving-end monitor for an LFSR counter driven through a load/cen/data
//   interface. It runs a cycle-accurate reference LFSR alongside the counter
//   and checks it against the counter's registered output q. The block flags
//   and counts mismatches, captures the first failure, detects all-zero
//   lockup and measures the sequence period.
//
// Parameters
//   WIDTH  : LFSR width; also the width of data, q, first_* and period
//   TAPS   : feedback tap mask
//   ERR_W  : width of the saturating error counter
//   RESYNC : 1 = after a mismatch, re-seed the reference from the observed q
//
// Ports
//   clk, rst_n   : clock (posedge) and asynchronous active-low reset
//   load, cen    : load strobe and count enable, as driven to the counter
//   data         : load value, as driven to the counter
//   q            : counter output under test
//   clr          : synchronous clear of err_cnt, err_seen and first_*
//   synced       : reference is valid and compares are running
//   mismatch     : one-cycle pulse for each failed compare
//   err_cnt      : saturating mismatch count
//   err_seen     : sticky flag, set by the first recorded mismatch
//   first_q      : q at the first recorded mismatch
//   first_exp    : expected value at the first recorded mismatch
//   locked_up    : sticky flag, reference stepped while all-zero
//   period       : last measured sequence period
//   period_valid : period holds a measurement taken since the last load
module lfsr_response_checker #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
  parameter int               ERR_W  = 16,
  parameter bit               RESYNC = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             cen,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] q,
  input  logic             clr,
  output logic             synced,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_seen,
  output logic [WIDTH-1:0] first_q,
  output logic [WIDTH-1:0] first_exp,
  output logic             locked_up,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [ERR_W-1:0] ONE_E = ERR_W'(1);

  // One step of the reference LFSR.
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  state_t state_q, state_d;

  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_seen_q, err_seen_d;
  logic [WIDTH-1:0] first_q_q, first_q_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic             locked_up_q, locked_up_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;

  logic             in_sync;
  logic             cmp_fail;
  logic             record;
  logic [WIDTH-1:0] exp_step;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: the first load syncs the reference. Only reset leaves SYNC.
  always_comb begin
    state_d = state_q;
    if (state_q == UNSYNC && load) begin
      state_d = SYNC;
    end
  end

  // FSM outputs.
  always_comb begin
    synced = (state_q == SYNC);
  end

  // Reference model, period measurement, lockup detection and error capture.
  // A mismatch that coincides with clr still pulses mismatch, but it is
  // neither counted nor captured.
  always_comb begin
    in_sync  = (state_q == SYNC);
    cmp_fail = in_sync && (q != exp_q);
    record   = cmp_fail && !clr;
    exp_step = nxt(exp_q);

    exp_d          = exp_q;
    seed_d         = seed_q;
    pcnt_d         = pcnt_q;
    mismatch_d     = cmp_fail;
    err_cnt_d      = err_cnt_q;
    err_seen_d     = err_seen_q;
    first_q_d      = first_q_q;
    first_exp_d    = first_exp_q;
    locked_up_d    = locked_up_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;

    if (!in_sync) begin
      if (load) begin
        exp_d  = data;
        seed_d = data;
        pcnt_d = '0;
      end
    end else begin
      if (load) begin
        exp_d          = data;
        seed_d         = data;
        pcnt_d         = '0;
        period_valid_d = 1'b0;
      end else if (cmp_fail && RESYNC) begin
        exp_d = cen ? nxt(q) : q;
      end else if (cen) begin
        exp_d = exp_step;
      end

      if (cen && !load) begin
        if (exp_q == '0) begin
          locked_up_d = 1'b1;
        end
        // A saturated count is no longer a trustworthy period, so it stays
        // pinned at all-ones until the next load re-seeds the measurement.
        if (pcnt_q != '1) begin
          if (exp_step == seed_q) begin
            period_d       = pcnt_q + ONE_W;
            period_valid_d = 1'b1;
            pcnt_d         = '0;
          end else begin
            pcnt_d = pcnt_q + ONE_W;
          end
        end
      end
    end

    if (clr) begin
      err_cnt_d   = '0;
      err_seen_d  = 1'b0;
      first_q_d   = '0;
      first_exp_d = '0;
    end else if (record) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ONE_E;
      end
      if (!err_seen_q) begin
        err_seen_d  = 1'b1;
        first_q_d   = q;
        first_exp_d = exp_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q          <= '0;
      seed_q         <= '0;
      pcnt_q         <= '0;
      mismatch_q     <= 1'b0;
      err_cnt_q      <= '0;
      err_seen_q     <= 1'b0;
      first_q_q      <= '0;
      first_exp_q    <= '0;
      locked_up_q    <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      exp_q          <= exp_d;
      seed_q         <= seed_d;
      pcnt_q         <= pcnt_d;
      mismatch_q     <= mismatch_d;
      err_cnt_q      <= err_cnt_d;
      err_seen_q     <= err_seen_d;
      first_q_q      <= first_q_d;
      first_exp_q    <= first_exp_d;
      locked_up_q    <= locked_up_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign mismatch     = mismatch_q;
  assign err_cnt      = err_cnt_q;
  assign err_seen     = err_seen_q;
  assign first_q      = first_q_q;
  assign first_exp    = first_exp_q;
  assign locked_up    = locked_up_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_response_checker.sv
// tb_lfsr_response_checker
//   Directed bench for lfsr_response_checker. Two checkers share one stimulus
//   stream: dut_a with RESYNC=0 and dut_b with RESYNC=1. q is driven by the
//   bench and stands in for the counter output that is valid during each cycle.
module tb_lfsr_response_checker;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        cen;
  logic [7:0]  data;
  logic [7:0]  q;
  logic        clr;

  logic        synced_a, mismatch_a, err_seen_a, locked_up_a, period_valid_a;
  logic [15:0] err_cnt_a;
  logic [7:0]  first_q_a, first_exp_a, period_a;

  logic        synced_b, mismatch_b, err_seen_b, locked_up_b, period_valid_b;
  logic [15:0] err_cnt_b;
  logic [7:0]  first_q_b, first_exp_b, period_b;

  int checks;
  int failures;

  lfsr_response_checker #(.WIDTH(8), .TAPS(8'hB8), .ERR_W(16), .RESYNC(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .cen(cen), .data(data), .q(q), .clr(clr),
    .synced(synced_a), .mismatch(mismatch_a), .err_cnt(err_cnt_a), .err_seen(err_seen_a),
    .first_q(first_q_a), .first_exp(first_exp_a), .locked_up(locked_up_a),
    .period(period_a), .period_valid(period_valid_a)
  );

  lfsr_response_checker #(.WIDTH(8), .TAPS(8'hB8), .ERR_W(16), .RESYNC(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .cen(cen), .data(data), .q(q), .clr(clr),
    .synced(synced_b), .mismatch(mismatch_b), .err_cnt(err_cnt_b), .err_seen(err_seen_b),
    .first_q(first_q_b), .first_exp(first_exp_b), .locked_up(locked_up_b),
    .period(period_b), .period_valid(period_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step of a correct counter, used to generate long q sequences.
  function automatic logic [7:0] lfsr_nxt(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample 1 time unit
  // after the following rising edge.
  task automatic cyc(input logic ld, input logic ce, input logic cl,
                     input logic [7:0] d, input logic [7:0] qv);
    @(negedge clk);
    load = ld;
    cen  = ce;
    clr  = cl;
    data = d;
    q    = qv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    cen   = 1'b0;
    clr   = 1'b0;
    data  = 8'h00;
    q     = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] sum_w;
    rst_n = 1'b0;
    load  = 1'b0;
    cen   = 1'b0;
    clr   = 1'b0;
    data  = 8'h00;
    q     = 8'hFF;
    #22;
    checks++;
    if ({synced_a, mismatch_a, err_seen_a, locked_up_a, period_valid_a} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=00000",
               {synced_a, mismatch_a, err_seen_a, locked_up_a, period_valid_a});
    end
    checks++;
    if (err_cnt_a !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_err_cnt got=%0h exp=0", err_cnt_a);
    end
    sum_w = first_q_a | first_exp_a | period_a;
    checks++;
    if (sum_w !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_regs got=%0h exp=0", sum_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
      checks++;
      if (synced_a !== 1'b0 || mismatch_a !== 1'b0) begin
        failures++;
        $display("[TB] FAIL nosync_cycle%0d got synced=%b mismatch=%b exp 0/0",
                 i, synced_a, mismatch_a);
      end
    end
    checks++;
    if (err_cnt_a !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL nosync_err_cnt got=%0h exp=0", err_cnt_a);
    end
  endtask

  task automatic test_track();
    logic [7:0] q_tab [5];
    q_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    checks++;
    if (synced_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL track_synced got=%b exp=1", synced_a);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, (i < 4), 1'b0, 8'h00, q_tab[i]);
      checks++;
      if (mismatch_a !== 1'b0 || mismatch_b !== 1'b0) begin
        failures++;
        $display("[TB] FAIL track_step%0d got a=%b b=%b exp 0/0", i, mismatch_a, mismatch_b);
      end
    end
    checks++;
    if (err_cnt_a !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL track_err_cnt got=%0h exp=0", err_cnt_a);
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] q_tab [5];
    logic       exp_a [5];
    logic       exp_b [5];
    q_tab = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h15};
    exp_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, q_tab[i]);
      checks++;
      if (mismatch_a !== exp_a[i] || mismatch_b !== exp_b[i]) begin
        failures++;
        $display("[TB] FAIL mm_pulse%0d got a=%b b=%b exp a=%b b=%b",
                 i, mismatch_a, mismatch_b, exp_a[i], exp_b[i]);
      end
      if (i == 2) begin
        checks++;
        if (err_cnt_a !== 16'd1 || first_q_a !== 8'h05 || first_exp_a !== 8'h04) begin
          failures++;
          $display("[TB] FAIL mm_first got cnt=%0h fq=%0h fe=%0h exp 1/05/04",
                   err_cnt_a, first_q_a, first_exp_a);
        end
      end
    end
    checks++;
    if (err_cnt_a !== 16'd3 || first_q_a !== 8'h05 || err_seen_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mm_norsync got cnt=%0h fq=%0h seen=%b exp 3/05/1",
               err_cnt_a, first_q_a, err_seen_a);
    end
    checks++;
    if (err_cnt_b !== 16'd1 || first_q_b !== 8'h05 || first_exp_b !== 8'h04) begin
      failures++;
      $display("[TB] FAIL mm_resync got cnt=%0h fq=%0h fe=%0h exp 1/05/04",
               err_cnt_b, first_q_b, first_exp_b);
    end
  endtask

  // Continues from test_mismatch: dut_a holds err_cnt=3 and exp=0x23.
  task automatic test_clear();
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    checks++;
    if (err_cnt_a !== 16'd0 || err_seen_a !== 1'b0 || first_q_a !== 8'h00 ||
        first_exp_a !== 8'h00) begin
      failures++;
      $display("[TB] FAIL clr_a got cnt=%0h seen=%b fq=%0h fe=%0h exp 0/0/0/0",
               err_cnt_a, err_seen_a, first_q_a, first_exp_a);
    end
    checks++;
    if (err_cnt_b !== 16'd0 || err_seen_b !== 1'b0 || synced_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clr_b got cnt=%0h seen=%b synced=%b exp 0/0/1",
               err_cnt_b, err_seen_b, synced_a);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (err_cnt_a !== 16'd1 || first_q_a !== 8'h00 || first_exp_a !== 8'h23) begin
      failures++;
      $display("[TB] FAIL clr_after got cnt=%0h fq=%0h fe=%0h exp 1/00/23",
               err_cnt_a, first_q_a, first_exp_a);
    end
  endtask

  task automatic test_period();
    logic [7:0] qm;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    qm = 8'h01;
    for (int s = 1; s <= 255; s++) begin
      if (s == 101) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 1'b0, 1'b0, 8'h00, qm);
        end
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00, qm);
      qm = lfsr_nxt(qm);
      if (s == 254) begin
        checks++;
        if (period_valid_a !== 1'b0) begin
          failures++;
          $display("[TB] FAIL period_early got pv=%b exp=0", period_valid_a);
        end
      end
    end
    checks++;
    if (period_valid_a !== 1'b1 || period_a !== 8'd255) begin
      failures++;
      $display("[TB] FAIL period_255 got pv=%b period=%0d exp 1/255", period_valid_a, period_a);
    end
    checks++;
    if (err_cnt_a !== 16'd0 || locked_up_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL period_clean got cnt=%0h lock=%b exp 0/0", err_cnt_a, locked_up_a);
    end
  endtask

  task automatic test_lockup();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
    checks++;
    if (locked_up_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lock_before got=%b exp=0", locked_up_a);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++;
    if (locked_up_a !== 1'b1 || period_a !== 8'd1 || period_valid_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lock_zero got lock=%b period=%0d pv=%b exp 1/1/1",
               locked_up_a, period_a, period_valid_a);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    checks++;
    if (locked_up_a !== 1'b1 || period_valid_a !== 1'b0 || err_cnt_a !== 16'd0) begin
      failures++;
      $display("[TB] FAIL lock_reload got lock=%b pv=%b cnt=%0h exp 1/0/0",
               locked_up_a, period_valid_a, err_cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
    cyc(1'b1, 1'b1, 1'b0, 8'h40, 8'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h40);
    checks++;
    if (mismatch_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_load_prio got=%b exp=0", mismatch_a);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h40);
    checks++;
    if (mismatch_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_hold got=%b exp=0", mismatch_a);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h10, 8'h41);
    checks++;
    if (mismatch_a !== 1'b1 || err_cnt_a !== 16'd1 || first_q_a !== 8'h41 ||
        first_exp_a !== 8'h40) begin
      failures++;
      $display("[TB] FAIL b2b_load_mm got mm=%b cnt=%0h fq=%0h fe=%0h exp 1/1/41/40",
               mismatch_a, err_cnt_a, first_q_a, first_exp_a);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h10);
    checks++;
    if (mismatch_a !== 1'b0 || err_cnt_a !== 16'd1) begin
      failures++;
      $display("[TB] FAIL b2b_reseed got mm=%b cnt=%0h exp 0/1", mismatch_a, err_cnt_a);
    end
  endtask

  // Continues from test_back_to_back with the checker synced and err_cnt=1.
  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (synced_a !== 1'b0 || err_cnt_a !== 16'd0 || err_seen_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_async got synced=%b cnt=%0h seen=%b exp 0/0/0",
               synced_a, err_cnt_a, err_seen_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h55);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'hAA);
    checks++;
    if (synced_a !== 1'b0 || mismatch_a !== 1'b0 || err_cnt_a !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midreset_nosync got synced=%b mm=%b cnt=%0h exp 0/0/0",
               synced_a, mismatch_a, err_cnt_a);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    for (int i = 0; i < 65538; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, (i % 2 == 0) ? 8'h80 : 8'h40);
      if (i == 65533) begin
        checks++;
        if (err_cnt_a !== 16'hFFFE) begin
          failures++;
          $display("[TB] FAIL sat_count got=%0h exp=fffe", err_cnt_a);
        end
      end
      if (i == 65534) begin
        checks++;
        if (err_cnt_a !== 16'hFFFF) begin
          failures++;
          $display("[TB] FAIL sat_reach got=%0h exp=ffff", err_cnt_a);
        end
      end
    end
    checks++;
    if (err_cnt_a !== 16'hFFFF || err_cnt_b !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_hold got a=%0h b=%0h exp ffff/ffff", err_cnt_a, err_cnt_b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_track();
    test_mismatch();
    test_clear();
    test_period();
    test_lockup();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
